// File: rtl/nested_counter_pkg.sv
// Shared types and default sizes for the nested loop counter.
package nested_counter_pkg;

  localparam int unsigned WORD_SIZE_DEF  = 16;
  localparam int unsigned NUM_LEVELS_DEF = 2;

  typedef enum logic {
    eIDLE = 1'b0,
    eRUN  = 1'b1
  } state_e;

  typedef logic [NUM_LEVELS_DEF-1:0][WORD_SIZE_DEF-1:0] count_vec_t;

endpackage

// File: rtl/nested_counter_if.sv
// Control and tuple handshake bundle of the nested loop counter.
interface nested_counter_if #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned NUM_LEVELS = 2
);

  logic                                  start_i;
  logic                                  continuous_i;
  logic                                  abort_i;
  logic [NUM_LEVELS-1:0][WORD_SIZE-1:0]  limit_i;
  logic                                  ready_i;
  logic                                  valid_o;
  logic [NUM_LEVELS-1:0][WORD_SIZE-1:0]  count_o;
  logic [NUM_LEVELS-1:0]                 last_o;
  logic                                  idle_o;
  logic                                  done_o;

  // Controller side: drives requests, consumes tuples.
  modport master (
    output start_i, continuous_i, abort_i, limit_i, ready_i,
    input  valid_o, count_o, last_o, idle_o, done_o
  );

  // Counter side.
  modport slave (
    input  start_i, continuous_i, abort_i, limit_i, ready_i,
    output valid_o, count_o, last_o, idle_o, done_o
  );

endinterface

// File: rtl/nested_counter_count_stage.sv
// One odometer digit: count register plus the limit latched at start.
module count_stage
  import nested_counter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic [WORD_SIZE-1:0] i_limit,
  input  logic                 i_step,
  output logic [WORD_SIZE-1:0] o_count,
  output logic                 o_at_limit,
  output logic                 o_carry
);

  logic [WORD_SIZE-1:0] r_count;
  logic [WORD_SIZE-1:0] r_limit;
  logic                 w_at_limit;

  assign w_at_limit = (r_count == r_limit);

  // Wrapping at the limit keeps the count in range, so the +1 never overflows.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_count <= '0;
      r_limit <= i_limit;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_step) begin
      r_count <= w_at_limit ? '0 : r_count + WORD_SIZE'(1);
    end
  end

  assign o_count    = r_count;
  assign o_at_limit = w_at_limit;
  assign o_carry    = i_step & w_at_limit;

endmodule

// File: rtl/nested_counter.sv
// Multi-level nested loop counter presenting index tuples on a valid/ready handshake.
module nested_counter
  import nested_counter_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned NUM_LEVELS = NUM_LEVELS_DEF
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  nested_counter_if.slave  bus
);

  state_e r_state;
  state_e w_state_next;
  logic   r_cont;
  logic   r_done;
  logic   w_valid;
  logic   w_load;
  logic   w_clear;
  logic   w_step0;
  logic   w_done_next;

  logic [NUM_LEVELS-1:0]                w_at_limit;
  logic [NUM_LEVELS-1:0]                w_carry;
  logic [NUM_LEVELS-1:0][WORD_SIZE-1:0] w_count;

  assign w_valid = (r_state == eRUN);

  // Abort wins over a simultaneous transfer, so it suppresses the step.
  assign w_step0 = w_valid & bus.ready_i & ~bus.abort_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= eIDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The carry out of the top level marks the transfer of the final tuple.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      eIDLE: begin
        if (bus.start_i) begin
          w_state_next = eRUN;
          w_load       = 1'b1;
        end
      end
      eRUN: begin
        if (bus.abort_i) begin
          w_state_next = eIDLE;
          w_clear      = 1'b1;
        end else if (w_carry[NUM_LEVELS-1] && !r_cont) begin
          w_state_next = eIDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = eIDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_cont <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
      if (w_load) begin
        r_cont <= bus.continuous_i;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_stage
    logic w_step;
    if (gi == 0) begin : g_first
      assign w_step = w_step0;
    end else begin : g_chain
      assign w_step = w_carry[gi-1];
    end

    count_stage #(
      .WORD_SIZE (WORD_SIZE)
    ) u_stage (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .i_clear    (w_clear),
      .i_load     (w_load),
      .i_limit    (bus.limit_i[gi]),
      .i_step     (w_step),
      .o_count    (w_count[gi]),
      .o_at_limit (w_at_limit[gi]),
      .o_carry    (w_carry[gi])
    );
  end

  assign bus.valid_o = w_valid;
  assign bus.count_o = w_count;
  assign bus.last_o  = {NUM_LEVELS{w_valid}} & w_at_limit;
  assign bus.idle_o  = (r_state == eIDLE);
  assign bus.done_o  = r_done;

endmodule

// File: tb/tb_nested_counter.sv
// Bench for nested_counter: vector table, directed corners and a randomized run against a tuple-index model.
module tb_nested_counter;
  import nested_counter_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned NL = 2;
  localparam int unsigned W4 = 4;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  nested_counter_if #(.WORD_SIZE(W),  .NUM_LEVELS(NL)) bus();
  nested_counter_if #(.WORD_SIZE(W4), .NUM_LEVELS(NL)) bus4();

  nested_counter #(.WORD_SIZE(W), .NUM_LEVELS(NL)) u_dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus.slave)
  );

  nested_counter #(.WORD_SIZE(W4), .NUM_LEVELS(NL)) u_dut4 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus4.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: position n within a sequence of prod(limit+1) tuples.
  bit              m_run, m_cont, m_done;
  longint unsigned m_n;
  int unsigned     m_lim [NL];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint unsigned seq_len();
    longint unsigned p = 1;
    for (int i = 0; i < NL; i++) p = p * (longint'(m_lim[i]) + 1);
    return p;
  endfunction

  function automatic longint unsigned digit(input int lvl);
    longint unsigned r = m_n;
    for (int i = 0; i < lvl; i++) r = r / (longint'(m_lim[i]) + 1);
    return r % (longint'(m_lim[lvl]) + 1);
  endfunction

  function automatic count_vec_t exp_count();
    count_vec_t c = '0;
    if (m_run) for (int i = 0; i < NL; i++) c[i] = W'(digit(i));
    return c;
  endfunction

  function automatic logic [NL-1:0] exp_last();
    logic [NL-1:0] l = '0;
    if (m_run) for (int i = 0; i < NL; i++) l[i] = (digit(i) == longint'(m_lim[i]));
    return l;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_cont = 1'b0; m_done = 1'b0; m_n = 0;
    for (int i = 0; i < NL; i++) m_lim[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit nd = 1'b0;
    if (!m_run) begin
      if (bus.start_i) begin
        m_run  = 1'b1;
        m_n    = 0;
        m_cont = bus.continuous_i;
        for (int i = 0; i < NL; i++) m_lim[i] = int'(bus.limit_i[i]);
      end
    end else if (bus.abort_i) begin
      m_run = 1'b0;
      m_n   = 0;
    end else if (bus.ready_i) begin
      if (m_n == seq_len() - 1) begin
        m_n = 0;
        if (!m_cont) begin
          m_run = 1'b0;
          nd    = 1'b1;
        end
      end else begin
        m_n++;
      end
    end
    m_done = nd;
  endtask

  task automatic check_model();
    chk("valid", 64'(bus.valid_o), 64'(m_run));
    chk("count", 64'(bus.count_o), 64'(exp_count()));
    chk("last",  64'(bus.last_o),  64'(exp_last()));
    chk("idle",  64'(bus.idle_o),  64'(!m_run));
    chk("done",  64'(bus.done_o),  64'(m_done));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_model();
  endtask

  task automatic drive(input bit st, input bit co, input bit ab, input bit rd,
                       input logic [W-1:0] l0, input logic [W-1:0] l1);
    bus.start_i      = st;
    bus.continuous_i = co;
    bus.abort_i      = ab;
    bus.ready_i      = rd;
    bus.limit_i[0]   = l0;
    bus.limit_i[1]   = l1;
  endtask

  typedef struct {
    bit st, co, ab, rd;
    logic [W-1:0] l0, l1;
    bit e_valid;
    logic [W-1:0] e_c0, e_c1;
    logic [1:0] e_last;
    bit e_idle, e_done;
  } vec_t;

  function automatic vec_t mk(input bit st, co, ab, rd, input int l0, l1,
                              input bit ev, input int c0, c1, input logic [1:0] el,
                              input bit ei, ed);
    vec_t v;
    v.st = st; v.co = co; v.ab = ab; v.rd = rd;
    v.l0 = W'(l0); v.l1 = W'(l1);
    v.e_valid = ev; v.e_c0 = W'(c0); v.e_c1 = W'(c1);
    v.e_last = el; v.e_idle = ei; v.e_done = ed;
    return v;
  endfunction

  vec_t tbl [16];
  logic [W-1:0] bp_q [$];

  initial begin
    int n_xfer;
    int guard;
    drive(0, 0, 0, 0, 0, 0);
    bus4.start_i = 1'b0; bus4.continuous_i = 1'b0; bus4.abort_i = 1'b0;
    bus4.ready_i = 1'b0; bus4.limit_i = '0;
    model_reset();

    #3;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_last",  64'(bus.last_o),  64'd0);
    chk("rst_idle",  64'(bus.idle_o),  64'd1);
    chk("rst_done",  64'(bus.done_o),  64'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // walk {inner 2, outer 1}, start on done cycle with {0,0}, continuous {1,0} then abort
    tbl[0]  = mk(1,0,0,1, 2,1,  1,0,0,2'b00,0,0);
    tbl[1]  = mk(0,0,0,1, 2,1,  1,1,0,2'b00,0,0);
    tbl[2]  = mk(0,0,0,1, 2,1,  1,2,0,2'b01,0,0);
    tbl[3]  = mk(0,0,0,1, 2,1,  1,0,1,2'b10,0,0);
    tbl[4]  = mk(0,0,0,1, 2,1,  1,1,1,2'b10,0,0);
    tbl[5]  = mk(0,0,0,1, 2,1,  1,2,1,2'b11,0,0);
    tbl[6]  = mk(0,0,0,1, 2,1,  0,0,0,2'b00,1,1);
    tbl[7]  = mk(1,0,0,0, 0,0,  1,0,0,2'b11,0,0);
    tbl[8]  = mk(0,0,0,1, 0,0,  0,0,0,2'b00,1,1);
    tbl[9]  = mk(0,0,0,1, 0,0,  0,0,0,2'b00,1,0);
    tbl[10] = mk(1,1,0,1, 1,0,  1,0,0,2'b10,0,0);
    tbl[11] = mk(0,0,0,1, 1,0,  1,1,0,2'b11,0,0);
    tbl[12] = mk(0,0,0,1, 1,0,  1,0,0,2'b10,0,0);
    tbl[13] = mk(0,0,0,1, 1,0,  1,1,0,2'b11,0,0);
    tbl[14] = mk(0,0,1,1, 1,0,  0,0,0,2'b00,1,0);
    tbl[15] = mk(0,0,0,0, 1,0,  0,0,0,2'b00,1,0);

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].st, tbl[k].co, tbl[k].ab, tbl[k].rd, tbl[k].l0, tbl[k].l1);
      model_step();
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_valid", k), 64'(bus.valid_o), 64'(tbl[k].e_valid));
      chk($sformatf("tbl%0d_c0", k),    64'(bus.count_o[0]), 64'(tbl[k].e_c0));
      chk($sformatf("tbl%0d_c1", k),    64'(bus.count_o[1]), 64'(tbl[k].e_c1));
      chk($sformatf("tbl%0d_last", k),  64'(bus.last_o), 64'(tbl[k].e_last));
      chk($sformatf("tbl%0d_idle", k),  64'(bus.idle_o), 64'(tbl[k].e_idle));
      chk($sformatf("tbl%0d_done", k),  64'(bus.done_o), 64'(tbl[k].e_done));
    end

    // backpressure: ready 1,0,0,1 repeating
    drive(1, 0, 0, 0, 2, 1);
    tick();
    bus.start_i = 1'b0;
    n_xfer = 0;
    guard  = 0;
    while (m_run && guard < 40) begin
      bus.ready_i = (guard % 4 == 0) || (guard % 4 == 3);
      if (bus.valid_o && bus.ready_i) begin
        bp_q.push_back(bus.count_o[1] * W'(3) + bus.count_o[0]);
        n_xfer++;
      end
      tick();
      guard++;
    end
    chk("bp_xfers", 64'(n_xfer), 64'd6);
    for (int k = 0; k < bp_q.size(); k++) chk($sformatf("bp_order%0d", k), 64'(bp_q[k]), 64'(k));

    // start and limit/mode changes during a run are ignored
    drive(1, 0, 0, 1, 1, 1);
    tick();
    drive(1, 1, 0, 1, 3, 3);
    tick(); tick(); tick();
    bus.start_i = 1'b0;
    tick();
    chk("ign_done", 64'(bus.done_o), 64'd1);
    tick();

    // abort coincident with the final one-shot transfer
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1, 0, 0);
    tick();
    chk("abfin_done", 64'(bus.done_o), 64'd0);
    chk("abfin_idle", 64'(bus.idle_o), 64'd1);
    bus.abort_i = 1'b0;
    tick();
    chk("abfin_done2", 64'(bus.done_o), 64'd0);

    // asynchronous reset at the third tuple
    drive(1, 0, 0, 1, 2, 1);
    tick();
    bus.start_i = 1'b0;
    tick(); tick();
    #2 reset_ni = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_last",  64'(bus.last_o),  64'd0);
    chk("arst_idle",  64'(bus.idle_o),  64'd1);
    chk("arst_done",  64'(bus.done_o),  64'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    drive(1, 0, 0, 0, 2, 1);
    tick();
    chk("arst_restart", 64'(bus.count_o), 64'd0);
    chk("arst_rvalid",  64'(bus.valid_o), 64'd1);
    drive(0, 0, 0, 1, 2, 1);
    guard = 0;
    while (m_run && guard < 20) begin
      tick();
      guard++;
    end
    chk("arst_finished", 64'(m_run), 64'd0);
    tick();

    // 4-bit counter at full-scale limits on both levels
    bus4.limit_i[0] = 4'd15;
    bus4.limit_i[1] = 4'd15;
    bus4.ready_i    = 1'b1;
    bus4.start_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus4.start_i = 1'b0;
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("w4_c%0d", k), 64'(bus4.count_o), 64'(((k / 16) << 4) | (k % 16)));
      chk($sformatf("w4_l%0d", k), 64'(bus4.last_o),
          64'({(k / 16) == 15, (k % 16) == 15}));
      @(posedge clk_i);
      @(negedge clk_i);
    end
    chk("w4_valid_end", 64'(bus4.valid_o), 64'd0);
    chk("w4_done_end",  64'(bus4.done_o),  64'd1);
    bus4.ready_i = 1'b0;
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    check_model();

    // randomized run against the model
    for (int k = 0; k < 600; k++) begin
      bus.start_i      = m_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      bus.continuous_i = 1'($urandom_range(0, 1));
      bus.abort_i      = ($urandom_range(0, 24) == 0);
      bus.ready_i      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.limit_i[0] = W'($urandom_range(0, 3));
        bus.limit_i[1] = W'($urandom_range(0, 3));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nested_counter.md
# nested_counter

Parametrised multi-level loop counter, the next generation of the single-level up counter. It walks NUM_LEVELS nested indices, with level 0 innermost, each from 0 to a per-level inclusive limit sampled at start. It presents each index tuple on a valid/ready output handshake and supports one-shot or continuous mode plus synchronous abort. It drives window, kernel and channel address sequencing in the CNN/FIR datapaths.

## Interface
- WORD_SIZE, 16, width of each level's count and limit
- NUM_LEVELS, 2, number of nested levels (≥1); level 0 innermost
- clk_i  input  1  clock, all state on rising edge
- reset_ni  input  1  asynchronous, active-low reset
- start_i  input  1  start request; accepted only when idle_o=1
- continuous_i  input  1  mode select, sampled with start_i: 1 = restart automatically after final tuple
- abort_i  input  1  synchronous abort of a running sequence
- limit_i  input  [NUM_LEVELS-1:0][WORD_SIZE-1:0]  per-level inclusive limit, sampled with start_i
- ready_i  input  1  downstream accepts current tuple
- valid_o  output  1  count_o holds a valid tuple
- count_o  output  [NUM_LEVELS-1:0][WORD_SIZE-1:0]  current index tuple
- last_o  output  [NUM_LEVELS-1:0]  per level: valid_o & (count==latched limit)
- idle_o  output  1  block idle, start_i will be accepted
- done_o  output  1  one-cycle pulse after final tuple of a one-shot sequence

## Operation
- FSM states: eIDLE, eRUN.
- eIDLE → eRUN on start_i. Limits and mode are latched, all counts are cleared to 0.
- A transfer occurs on a cycle with valid_o & ready_i.
- On each transfer, level 0 increments. A level at its latched limit wraps to 0 and carries into the next level, like an odometer.
- With no transfer, count_o holds stable. ready_i may toggle freely.
- Final tuple: all last_o bits set.
  - Transfer of the final tuple in one-shot mode → eIDLE, counts cleared, done_o=1 next cycle.
  - Transfer of the final tuple in continuous mode → stay eRUN, counts wrap to all-zero, no done_o.
- abort_i in eRUN → eIDLE next cycle, counts cleared, valid_o=0, no done_o. abort_i has priority over a simultaneous transfer. abort_i in eIDLE has no effect.
- start_i in eRUN is ignored. start_i together with abort_i in eIDLE is a start.
- Limit 0 on a level: that level stays 0, its last_o is 1 whenever valid_o=1, and it carries on every transfer.
- Counts never exceed the latched limits, so there is no overflow. A limit of 2^WORD_SIZE-1 is legal.
- Sequence length is the product of (limit+1) over all levels.
- limit_i and continuous_i changes during eRUN are ignored.

## Timing
- Reset values: valid_o=0, count_o=0, last_o=0, idle_o=1, done_o=0, latched limits=0, state=eIDLE.
- Reset mid-sequence returns to the reset state immediately (asynchronous). The sequence is not resumed.
- Start latency: start_i high at cycle t → valid_o=1 with count_o=0 at t+1, idle_o=0 at t+1.
- Throughput: one tuple per cycle while ready_i=1.
- Counter update: registered, one cycle after the transfer edge. last_o and idle_o are decoded from registered state.
- Final one-shot transfer at cycle t: valid_o=0, idle_o=1, done_o=1 at t+1; done_o=0 at t+2.
  - A new start_i at t+1 is accepted, giving valid_o at t+2.
- Continuous wrap: final transfer at cycle t → count_o=0, valid_o=1 at t+1, with no bubble.

## Structure
- Package nested_counter_pkg holds:
  - state enum {eIDLE, eRUN}
  - typedef for the packed count vector, parameterised via localparam defaults
- Sub-module count_stage, one instance per level via generate:
  - holds the count register and latched limit
  - inputs: clear, load, step (carry-in)
  - outputs: at_limit, carry-out = step & at_limit
- Top level contains the FSM, handshake, done pulse, and the carry chain linking the stages.

## Test plan
- Basic walk: NUM_LEVELS=2, limits {2,1}, one-shot, ready_i=1 → 6 tuples (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) as (outer,inner) on consecutive cycles; last_o=2'b11 on the sixth; done_o one cycle after the sixth; idle_o returns to 1.
- Backpressure: same limits, ready_i toggling 1,0,0,1,… → count_o held stable while ready_i=0; exactly 6 transfers; tuple order unchanged.
- Continuous mode: limits {1,0} → sequence (0,0),(0,1),(0,0),(0,1)… with no idle cycle and no done_o; then abort_i → valid_o=0 and idle_o=1 next cycle, done_o never asserted.
- Edge limits: limits {0,0} → single tuple with last_o=2'b11 and done_o; WORD_SIZE=4, limit 15 on level 0 → 16 tuples, wrap to 0 with no overflow.
- Control corners:
  - start_i during eRUN is ignored
  - limit_i changed mid-run has no effect
  - abort_i coincident with final transfer gives no done_o
  - start_i on the done_o cycle starts a new sequence
- Reset mid-run: deassert reset_ni asynchronously (between clock edges) at tuple 3 → all outputs at reset values immediately; after release, a fresh start_i restarts from (0,0).
